// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Memory-side controller for the dual-issue LSU stage. The slot-0/slot-1
// load/store pair held in the EX/LSU registers is serialised onto a single
// outstanding data-memory bus, slot 0 first. While either slot still owes a
// bus access the pipeline is held through mem_stall_o. Load results are
// aligned, extended and registered into the LSU/WB stage on pipeline advance.
//
// Ports
//   clock_i, reset_i          core clock, synchronous active-high reset
//   backend_we_i              pipeline advance strobe
//   mem_op_N_i                slot op: 00/11 none, 01 load, 10 store
//   funct3_N_i                RV32I size/sign field of slot N
//   addr_N_i, sdata_N_i       effective address and store data of slot N
//   mem_stall_o               pair not finished, hold the pipeline
//   misalign_N_o              slot N misaligned, no bus access is made
//   req_*                     bus request channel (valid/ready handshake)
//   resp_valid_i, resp_rdata_i  bus response (loads and stores both respond)
//   ldata_N_wb_o              slot N load result in the WB stage
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            backend_we_i,
  input  logic [1:0]      mem_op_0_i,
  input  logic [1:0]      mem_op_1_i,
  input  logic [2:0]      funct3_0_i,
  input  logic [2:0]      funct3_1_i,
  input  logic [XLEN-1:0] addr_0_i,
  input  logic [XLEN-1:0] addr_1_i,
  input  logic [XLEN-1:0] sdata_0_i,
  input  logic [XLEN-1:0] sdata_1_i,
  output logic            mem_stall_o,
  output logic            misalign_0_o,
  output logic            misalign_1_o,
  output logic            req_valid_o,
  input  logic            req_ready_i,
  output logic            req_we_o,
  output logic [XLEN-1:0] req_addr_o,
  output logic [XLEN-1:0] req_wdata_o,
  output logic [BE_W-1:0] req_be_o,
  input  logic            resp_valid_i,
  input  logic [XLEN-1:0] resp_rdata_i,
  output logic [XLEN-1:0] ldata_0_wb_o,
  output logic [XLEN-1:0] ldata_1_wb_o
);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t          state_q;
  logic            done0_q;
  logic            done1_q;
  logic            slot_q;
  logic            isLoad_q;
  logic [2:0]      funct3_q;
  logic [1:0]      addrLo_q;
  logic [XLEN-1:0] ld0_q;
  logic [XLEN-1:0] ld1_q;

  logic            isMem0;
  logic            isMem1;
  logic            aligned0;
  logic            aligned1;
  logic            pend0;
  logic            pend1;
  logic            selSlot;
  logic            reqValid;
  logic [1:0]      selOp;
  logic [2:0]      selF3;
  logic [XLEN-1:0] selAddr;
  logic [XLEN-1:0] selData;

  // Byte accesses are always aligned, halves need addr[0]=0, words need
  // addr[1:0]=0. The reserved size code 11 is held to the word rule.
  function automatic logic isAligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b1;
      2'b01:   return !lo[0];
      default: return (lo == 2'b00);
    endcase
  endfunction

  // Picks the addressed byte or half out of the raw bus word and sign/zero
  // extends it according to funct3.
  function automatic logic [XLEN-1:0] extractLoad(input logic [2:0] f3,
                                                  input logic [1:0] lo,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(XLEN-8){b[7]}}, b};
      3'b001:  return {{(XLEN-16){h[15]}}, h};
      3'b100:  return {{(XLEN-8){1'b0}}, b};
      3'b101:  return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  // A slot owes a bus access when it is a load/store with a legal alignment
  // and has not yet completed for the pair currently held. Misaligned
  // accesses are flagged and treated as already complete.
  assign isMem0       = (mem_op_0_i == OP_LOAD) || (mem_op_0_i == OP_STORE);
  assign isMem1       = (mem_op_1_i == OP_LOAD) || (mem_op_1_i == OP_STORE);
  assign aligned0     = isAligned(funct3_0_i, addr_0_i[1:0]);
  assign aligned1     = isAligned(funct3_1_i, addr_1_i[1:0]);
  assign misalign_0_o = isMem0 && !aligned0;
  assign misalign_1_o = isMem1 && !aligned1;
  assign pend0        = isMem0 && aligned0 && !done0_q;
  assign pend1        = isMem1 && aligned1 && !done1_q;
  assign mem_stall_o  = pend0 || pend1;

  // Slot 0 always wins, so slot 1 only issues once slot 0 has completed.
  // This keeps a store->load pair to the same address in program order.
  assign selSlot  = !pend0;
  assign selOp    = selSlot ? mem_op_1_i : mem_op_0_i;
  assign selF3    = selSlot ? funct3_1_i : funct3_0_i;
  assign selAddr  = selSlot ? addr_1_i   : addr_0_i;
  assign selData  = selSlot ? sdata_1_i  : sdata_0_i;
  assign reqValid = (state_q == ST_IDLE) && (pend0 || pend1);
  assign req_valid_o = reqValid;

  // Request fields are derived straight from the held pipeline registers, so
  // they stay stable while the bus withholds ready. When no request is being
  // presented every field is driven to zero. Store data is replicated across
  // all lanes and the byte enables mark the lanes actually written.
  always_comb begin
    req_we_o    = 1'b0;
    req_addr_o  = '0;
    req_wdata_o = '0;
    req_be_o    = '0;
    if (reqValid) begin
      req_we_o   = (selOp == OP_STORE);
      req_addr_o = {selAddr[XLEN-1:2], 2'b00};
      case (selF3[1:0])
        2'b00: begin
          req_be_o    = BE_W'(1) << selAddr[1:0];
          req_wdata_o = {BE_W{selData[7:0]}};
        end
        2'b01: begin
          req_be_o    = BE_W'(3) << {selAddr[1], 1'b0};
          req_wdata_o = {(BE_W/2){selData[15:0]}};
        end
        default: begin
          req_be_o    = '1;
          req_wdata_o = selData;
        end
      endcase
      if (selOp != OP_STORE) begin
        req_wdata_o = '0;
      end
    end
  end

  // Single-outstanding bus FSM plus the per-slot completion bookkeeping.
  // IDLE presents the oldest pending slot and moves to WAIT on acceptance,
  // remembering which slot and how to extract its data. WAIT marks that slot
  // done on the response and captures load data. A response seen in IDLE
  // (for example after a reset mid-transaction) is dropped. Pipeline advance
  // clears the done bits and moves captured load data into the WB registers;
  // without advance the done bits and data simply hold.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      slot_q       <= 1'b0;
      isLoad_q     <= 1'b0;
      funct3_q     <= '0;
      addrLo_q     <= '0;
      ld0_q        <= '0;
      ld1_q        <= '0;
      ldata_0_wb_o <= '0;
      ldata_1_wb_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (reqValid && req_ready_i) begin
            state_q  <= ST_WAIT;
            slot_q   <= selSlot;
            isLoad_q <= (selOp == OP_LOAD);
            funct3_q <= selF3;
            addrLo_q <= selAddr[1:0];
          end
        end
        ST_WAIT: begin
          if (resp_valid_i) begin
            state_q <= ST_IDLE;
            if (slot_q) begin
              done1_q <= 1'b1;
            end else begin
              done0_q <= 1'b1;
            end
            if (isLoad_q) begin
              if (slot_q) begin
                ld1_q <= extractLoad(funct3_q, addrLo_q, resp_rdata_i);
              end else begin
                ld0_q <= extractLoad(funct3_q, addrLo_q, resp_rdata_i);
              end
            end
          end
        end
      endcase
      if (backend_we_i) begin
        done0_q      <= 1'b0;
        done1_q      <= 1'b0;
        ldata_0_wb_o <= ld0_q;
        ldata_1_wb_o <= ld1_q;
        ld0_q        <= '0;
        ld1_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Scoreboard bench for lsu_mem_ctrl. Each applied pair is run through a
// byte-addressed reference memory model; the expected bus requests and the
// expected WB load results are queued, and an independent monitor pops and
// compares them whenever the DUT accepts a request or the pipeline advances.
// A bus responder process backs the DUT with its own word memory.
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        backend_we_i;
  logic [1:0]  mem_op_0_i;
  logic [1:0]  mem_op_1_i;
  logic [2:0]  funct3_0_i;
  logic [2:0]  funct3_1_i;
  logic [31:0] addr_0_i;
  logic [31:0] addr_1_i;
  logic [31:0] sdata_0_i;
  logic [31:0] sdata_1_i;
  logic        mem_stall_o;
  logic        misalign_0_o;
  logic        misalign_1_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_we_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_be_o;
  logic        resp_valid_i;
  logic [31:0] resp_rdata_i;
  logic [31:0] ldata_0_wb_o;
  logic [31:0] ldata_1_wb_o;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } reqExp_t;

  typedef struct {
    logic [31:0] ld0;
    logic [31:0] ld1;
  } wbExp_t;

  reqExp_t     reqQ[$];
  wbExp_t      wbQ[$];
  int          assertCount = 0;
  int          failCount = 0;
  logic [7:0]  refBytes[bit [31:0]];
  logic [31:0] busWords[bit [31:0]];

  int          readyLowCycles = 0;
  bit          readyRandom = 1'b0;
  int          respDelay = 0;
  bit          advSeen = 1'b0;

  lsu_mem_ctrl #(.XLEN(32), .BE_W(4)) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .backend_we_i (backend_we_i),
    .mem_op_0_i   (mem_op_0_i),
    .mem_op_1_i   (mem_op_1_i),
    .funct3_0_i   (funct3_0_i),
    .funct3_1_i   (funct3_1_i),
    .addr_0_i     (addr_0_i),
    .addr_1_i     (addr_1_i),
    .sdata_0_i    (sdata_0_i),
    .sdata_1_i    (sdata_1_i),
    .mem_stall_o  (mem_stall_o),
    .misalign_0_o (misalign_0_o),
    .misalign_1_o (misalign_1_o),
    .req_valid_o  (req_valid_o),
    .req_ready_i  (req_ready_i),
    .req_we_o     (req_we_o),
    .req_addr_o   (req_addr_o),
    .req_wdata_o  (req_wdata_o),
    .req_be_o     (req_be_o),
    .resp_valid_i (resp_valid_i),
    .resp_rdata_i (resp_rdata_i),
    .ldata_0_wb_o (ldata_0_wb_o),
    .ldata_1_wb_o (ldata_1_wb_o)
  );

  // Free-running 10-unit clock.
  always #5 clock_i = ~clock_i;

  // Remember whether the edge that just happened was a pipeline advance, so
  // the monitor knows the WB registers have new contents to check.
  always @(posedge clock_i) advSeen = backend_we_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [7:0] refByte(input logic [31:0] a);
    logic [31:0] w;
    if (refBytes.exists(a)) return refBytes[a];
    w = initWord({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic logic [31:0] busRead(input logic [31:0] a);
    if (busWords.exists(a)) return busWords[a];
    return initWord(a);
  endfunction

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = busRead(a);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    busWords[a] = w;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] w);
    busWords[a] = w;
    for (int i = 0; i < 4; i++) refBytes[a + 32'(i)] = w[8*i +: 8];
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Reference behaviour of one slot in program order: misaligned or non-memory
  // ops make no access; stores update the byte memory; loads gather bytes and
  // extend. The bus request the slot should produce is queued here.
  task automatic modelSlot(input logic [1:0] op, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] ld, output bit need, output bit mis);
    int      sz;
    int      beInt;
    reqExp_t e;
    logic [31:0] v;
    sz   = accessSize(f3);
    ld   = 32'h0;
    need = 1'b0;
    mis  = 1'b0;
    if (op != OP_LOAD && op != OP_STORE) return;
    if ((int'(addr[1:0]) % sz) != 0) begin
      mis = 1'b1;
      return;
    end
    need   = 1'b1;
    beInt  = ((1 << sz) - 1) << addr[1:0];
    e.we   = (op == OP_STORE);
    e.addr = {addr[31:2], 2'b00};
    e.be   = beInt[3:0];
    e.wdata = (sz == 1) ? {4{data[7:0]}} : (sz == 2) ? {2{data[15:0]}} : data;
    reqQ.push_back(e);
    if (op == OP_STORE) begin
      for (int i = 0; i < sz; i++) refBytes[addr + 32'(i)] = data[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = refByte(addr + 32'(i));
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      ld = v;
    end
  endtask

  // Bus responder: drives ready (always, random, or held low for a number of
  // cycles) and answers each accepted request after respDelay extra cycles,
  // reading or writing its own word memory using the DUT's byte enables.
  initial begin
    bit          respPending;
    int          respWait;
    logic        accWe;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    logic [3:0]  accBe;
    respPending  = 1'b0;
    respWait     = 0;
    accWe        = 1'b0;
    accAddr      = '0;
    accWdata     = '0;
    accBe        = '0;
    req_ready_i  = 1'b0;
    resp_valid_i = 1'b0;
    resp_rdata_i = '0;
    forever begin
      @(posedge clock_i); #1;
      resp_valid_i = 1'b0;
      resp_rdata_i = $urandom();
      if (respPending) begin
        if (respWait == 0) begin
          resp_valid_i = 1'b1;
          respPending  = 1'b0;
          if (accWe) busWrite(accAddr, accWdata, accBe);
          else resp_rdata_i = busRead(accAddr);
        end else begin
          respWait--;
        end
      end
      if (readyLowCycles > 0) begin
        req_ready_i = 1'b0;
        readyLowCycles--;
      end else if (readyRandom) begin
        req_ready_i = ($urandom_range(0, 3) != 0);
      end else begin
        req_ready_i = 1'b1;
      end
      @(negedge clock_i);
      if (req_valid_o && req_ready_i) begin
        respPending = 1'b1;
        respWait    = respDelay;
        accWe       = req_we_o;
        accAddr     = req_addr_o;
        accWdata    = req_wdata_o;
        accBe       = req_be_o;
      end
    end
  end

  // Monitor: compares every accepted request with the head of the request
  // queue, checks that a request held off by ready stays stable, and checks
  // the WB load registers after each pipeline advance.
  initial begin
    bit          heldPrev;
    logic        heldWe;
    logic [31:0] heldAddr;
    logic [31:0] heldWdata;
    logic [3:0]  heldBe;
    reqExp_t     e;
    wbExp_t      w;
    heldPrev = 1'b0;
    forever begin
      @(negedge clock_i);
      if (req_valid_o) begin
        if (heldPrev) begin
          checkOutput("reqStableAddr", req_addr_o, heldAddr);
          checkOutput("reqStableCtl", {27'h0, req_we_o, req_be_o}, {27'h0, heldWe, heldBe});
          checkOutput("reqStableWdata", req_wdata_o, heldWdata);
        end
        if (req_ready_i) begin
          heldPrev = 1'b0;
          if (reqQ.size() == 0) begin
            checkOutput("unexpectedReqValid", 32'(req_valid_o), 32'h0);
          end else begin
            e = reqQ.pop_front();
            checkOutput("reqWe", 32'(req_we_o), 32'(e.we));
            checkOutput("reqAddr", req_addr_o, e.addr);
            if (e.we) begin
              checkOutput("reqBe", 32'(req_be_o), 32'(e.be));
              checkOutput("reqWdata", req_wdata_o, e.wdata);
            end
          end
        end else begin
          heldPrev  = 1'b1;
          heldWe    = req_we_o;
          heldAddr  = req_addr_o;
          heldWdata = req_wdata_o;
          heldBe    = req_be_o;
        end
      end else begin
        if (heldPrev) checkOutput("reqDroppedBeforeAccept", 32'(req_valid_o), 32'h1);
        heldPrev = 1'b0;
      end
      if (advSeen) begin
        if (wbQ.size() == 0) begin
          checkOutput("unexpectedAdvance", 32'(wbQ.size()), 32'h1);
        end else begin
          w = wbQ.pop_front();
          checkOutput("ldata0Wb", ldata_0_wb_o, w.ld0);
          checkOutput("ldata1Wb", ldata_1_wb_o, w.ld1);
        end
      end
    end
  end

  task automatic clearInputs();
    mem_op_0_i = OP_NONE;
    mem_op_1_i = OP_NONE;
    funct3_0_i = '0;
    funct3_1_i = '0;
    addr_0_i   = '0;
    addr_1_i   = '0;
    sdata_0_i  = '0;
    sdata_1_i  = '0;
  endtask

  // Presents one pair, waits (bounded) for the stall to drop, optionally
  // holds a few non-advancing cycles, then advances the pipeline.
  task automatic applyStimulus(input logic [1:0] o0, input logic [2:0] f0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic [1:0] o1, input logic [2:0] f1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input int expStall, input int lowCycles,
                               input bit randReady, input int delay,
                               input int holdCycles, input string tag);
    logic [31:0] ld0;
    logic [31:0] ld1;
    bit          n0;
    bit          n1;
    bit          m0;
    bit          m1;
    int          stallCount;
    wbExp_t      w;
    @(negedge clock_i);
    readyLowCycles = lowCycles;
    readyRandom    = randReady;
    respDelay      = delay;
    @(posedge clock_i); #1;
    mem_op_0_i = o0; funct3_0_i = f0; addr_0_i = a0; sdata_0_i = d0;
    mem_op_1_i = o1; funct3_1_i = f1; addr_1_i = a1; sdata_1_i = d1;
    modelSlot(o0, f0, a0, d0, ld0, n0, m0);
    modelSlot(o1, f1, a1, d1, ld1, n1, m1);
    w.ld0 = ld0;
    w.ld1 = ld1;
    wbQ.push_back(w);
    @(negedge clock_i);
    checkOutput({tag, "_misalign0"}, 32'(misalign_0_o), 32'(m0));
    checkOutput({tag, "_misalign1"}, 32'(misalign_1_o), 32'(m1));
    checkOutput({tag, "_stallFirst"}, 32'(mem_stall_o), 32'(n0 | n1));
    stallCount = 0;
    while (mem_stall_o && stallCount < 200) begin
      stallCount++;
      @(negedge clock_i);
    end
    if (stallCount >= 200) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s_stallTimeout: stall still 1 after %0d cycles, expected 0", tag, stallCount);
    end
    if (expStall >= 0) checkOutput({tag, "_stallCycles"}, 32'(stallCount), 32'(expStall));
    repeat (holdCycles) @(negedge clock_i);
    @(posedge clock_i); #1;
    backend_we_i = 1'b1;
    @(posedge clock_i); #1;
    backend_we_i = 1'b0;
    clearInputs();
  endtask

  // Load accepted, reset asserted while waiting, response arrives after the
  // reset: it must be dropped, leaving no done bit and no captured data.
  task automatic resetInWait();
    logic [31:0] ld;
    bit          n;
    bit          m;
    wbExp_t      w;
    @(negedge clock_i);
    readyLowCycles = 0;
    readyRandom    = 1'b0;
    respDelay      = 2;
    @(posedge clock_i); #1;
    mem_op_0_i = OP_LOAD; funct3_0_i = 3'b010; addr_0_i = 32'h300;
    modelSlot(OP_LOAD, 3'b010, 32'h300, 32'h0, ld, n, m);
    @(negedge clock_i);
    @(posedge clock_i); #1;
    reset_i = 1'b1;
    clearInputs();
    @(negedge clock_i);
    checkOutput("rstWait_reqValidInWait", 32'(req_valid_o), 32'h0);
    @(posedge clock_i); #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    checkOutput("rstWait_stall", 32'(mem_stall_o), 32'h0);
    checkOutput("rstWait_ldata0", ldata_0_wb_o, 32'h0);
    checkOutput("rstWait_ldata1", ldata_1_wb_o, 32'h0);
    repeat (3) begin
      @(negedge clock_i);
      checkOutput("rstWait_reqValidAfter", 32'(req_valid_o), 32'h0);
    end
    w.ld0 = 32'h0;
    w.ld1 = 32'h0;
    wbQ.push_back(w);
    @(posedge clock_i); #1;
    backend_we_i = 1'b1;
    @(posedge clock_i); #1;
    backend_we_i = 1'b0;
  endtask

  // Main sequence: reset checks, directed scenarios, a reset-in-WAIT case,
  // then randomized pairs in a small shared address window so stores and
  // loads collide, and finally a check that nothing was left unmatched.
  initial begin
    logic [2:0] loadF3[5];
    logic [1:0] o0, o1;
    logic [2:0] f0, f1;
    logic [31:0] a0, a1;
    loadF3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    reset_i      = 1'b1;
    backend_we_i = 1'b0;
    clearInputs();
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    checkOutput("reset_stall", 32'(mem_stall_o), 32'h0);
    checkOutput("reset_reqValid", 32'(req_valid_o), 32'h0);
    checkOutput("reset_ldata0", ldata_0_wb_o, 32'h0);
    checkOutput("reset_ldata1", ldata_1_wb_o, 32'h0);
    @(posedge clock_i); #1;
    reset_i = 1'b0;

    preload(32'h100, 32'hDEADBEEF);
    applyStimulus(OP_LOAD, 3'b010, 32'h100, 32'h0, OP_NONE, 3'b000, 32'h0, 32'h0,
                  2, 0, 1'b0, 0, 1, "lwSingle");
    applyStimulus(OP_STORE, 3'b010, 32'h200, 32'h11223344, OP_LOAD, 3'b000, 32'h203, 32'h0,
                  4, 0, 1'b0, 0, 3, "swThenLb");
    applyStimulus(OP_LOAD, 3'b001, 32'h101, 32'h0, OP_NONE, 3'b000, 32'h0, 32'h0,
                  0, 0, 1'b0, 0, 0, "lhMisalign");
    preload(32'h100, 32'h00800000);
    applyStimulus(OP_LOAD, 3'b100, 32'h102, 32'h0, OP_LOAD, 3'b000, 32'h102, 32'h0,
                  4, 0, 1'b0, 0, 0, "lbuLb");
    applyStimulus(OP_STORE, 3'b001, 32'h102, 32'h0000ABCD, OP_NONE, 3'b000, 32'h0, 32'h0,
                  2, 0, 1'b0, 0, 0, "shUpper");
    applyStimulus(OP_LOAD, 3'b010, 32'h104, 32'h0, OP_NONE, 3'b000, 32'h0, 32'h0,
                  5, 3, 1'b0, 0, 0, "readyLow");
    resetInWait();
    applyStimulus(OP_LOAD, 3'b010, 32'h300, 32'h0, OP_NONE, 3'b000, 32'h0, 32'h0,
                  2, 0, 1'b0, 0, 0, "afterReset");

    for (int n = 0; n < 80; n++) begin
      o0 = 2'($urandom_range(0, 3));
      o1 = 2'($urandom_range(0, 3));
      f0 = (o0 == OP_LOAD) ? loadF3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      f1 = (o1 == OP_LOAD) ? loadF3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
      a0 = 32'h2000 + 32'($urandom_range(0, 11));
      a1 = 32'h2000 + 32'($urandom_range(0, 11));
      if ($urandom_range(0, 4) == 0) a1 = $urandom();
      applyStimulus(o0, f0, a0, $urandom(), o1, f1, a1, $urandom(),
                    -1, 0, 1'b1, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
    end

    repeat (4) @(negedge clock_i);
    checkOutput("reqQueueDrained", 32'(reqQ.size()), 32'h0);
    checkOutput("wbQueueDrained", 32'(wbQ.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
